// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a synchronous FIFO read port into a valid/ready stream via a 2-entry holding buffer
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 rd_en_o,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 empty_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_o,
    input  logic                 ready_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic             tail;
    logic [1:0]       held;
    logic             inflight;
    logic [1:0]       used;
    logic             pop;
    logic             capture;

    assign valid_o = held != 2'd0;
    assign data_o  = valid_o ? mem[head] : '0;
    assign pop     = valid_o && ready_i && !flush_i;
    assign capture = inflight && !flush_i;
    assign used    = held + 2'(inflight);
    // a slot is free if fewer than two words are held or in flight, or one leaves this cycle
    assign rd_en_o = rst_ni && !flush_i && !empty_i && (used < 2'd2 || pop);

    // holding buffer, in-flight tracking and delivered-word counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            held     <= 2'd0;
            inflight <= 1'b0;
            count_o  <= '0;
        end else begin
            inflight <= rd_en_o;
            if (flush_i) begin
                held <= 2'd0;
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                held <= held + 2'(capture) - 2'(pop);
                if (capture) begin
                    mem[tail] <= rdata_i;
                    tail      <= ~tail;
                end
                if (pop) begin
                    head    <= ~head;
                    count_o <= count_o + CNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed stimulus with a scoreboard monitor for fifo_stream_reader
module tb_fifo_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rd_en;
    logic       empty = 1'b1;
    logic       valid;
    logic       ready = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic [7:0] data;
    logic [3:0] count;
    logic       rd_error = 1'b0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         nchk = 0;
    int         nfail = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rd_en_o(rd_en), .rdata_i(rdata), .empty_i(empty),
        .valid_o(valid), .data_o(data), .ready_i(ready), .flush_i(flush), .count_o(count)
    );

    // synchronous FIFO model with one-cycle read latency; not reset by rst_n
    always @(posedge clk) begin
        if (rd_en) begin
            if (fq.size() == 0) rd_error <= 1'b1;
            else rdata <= fq.pop_front();
        end
        empty <= (fq.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic sample(input string name, input int n, input logic [15:0] rd_pat, input logic [15:0] v_pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, " rd_en"}, 32'(rd_en), 32'(rd_pat[i]));
            check({name, " valid"}, 32'(valid), 32'(v_pat[i]));
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (exp_q.size() != 0 || valid); i++) @(negedge clk);
        check({name, " drain left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard monitor and invariants, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_en while empty", 32'(rd_en && empty), 32'd0);
            check("used bound", 32'((32'(dut.held) + 32'(dut.inflight)) > 32'd2), 32'd0);
            if (valid && ready && !flush) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL data: got %0h expected none", data);
                end else begin
                    check("data", 32'(data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset valid", 32'(valid), 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset data", 32'(data), 32'd0);
        check("reset count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // stream of five words with ready high
        @(posedge clk); #1;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        sample("stream", 10, 16'h003E, 16'h00F8);
        drain("stream");
        check("stream count", 32'(count), 32'd5);

        // backpressure: two reads outstanding then stall
        @(posedge clk); #1;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        sample("bp hold", 6, 16'h0006, 16'h0038);
        check("bp data stable", 32'(data), 32'h21);
        @(posedge clk); #1;
        ready = 1'b1;
        sample("bp release", 5, 16'h0003, 16'h000F);
        drain("bp");
        check("bp count", 32'(count), 32'd9);

        // empty boundary: second word arrives three cycles after the first
        @(posedge clk); #1;
        push(8'h31);
        sample("empty a", 3, 16'h0002, 16'h0000);
        @(posedge clk); #1;
        push(8'h32);
        sample("empty b", 6, 16'h0002, 16'h0009);
        drain("empty");
        check("empty count", 32'(count), 32'd11);

        // flush with one held and one in flight, ready raised during flush
        @(posedge clk); #1;
        ready = 1'b0;
        push(8'h41);
        push(8'h42);
        sample("flush pre", 3, 16'h0006, 16'h0000);
        @(posedge clk); #1;
        flush = 1'b1;
        ready = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        check("flush rd_en", 32'(rd_en), 32'd0);
        check("flush valid during", 32'(valid), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush valid after", 32'(valid), 32'd0);
        check("flush count", 32'(count), 32'd11);
        @(posedge clk); #1;
        push(8'h43);
        push(8'h44);
        drain("flush");
        check("flush count post", 32'(count), 32'd13);

        // asynchronous reset mid-stream
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push(8'h51 + 8'(i));
        sample("areset pre", 5, 16'h001E, 16'h0018);
        #2 rst_n = 1'b0;
        #1;
        check("areset valid", 32'(valid), 32'd0);
        check("areset rd_en", 32'(rd_en), 32'd0);
        check("areset data", 32'(data), 32'd0);
        check("areset count", 32'(count), 32'd0);
        void'(exp_q.pop_front());
        @(posedge clk); #3;
        rst_n = 1'b1;
        drain("areset");
        check("areset count post", 32'(count), 32'd3);

        // counter wrap over seventeen words
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("wrap count start", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        repeat (3) @(posedge clk);
        #1 push(8'h70);
        drain("wrap");
        check("wrap count", 32'(count), 32'd1);

        check("rd_error", 32'(rd_error), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the team's synchronous FIFO. It drives the FIFO read port (`rd_en`/`rdata`/`empty`) and turns it into a valid/ready output stream. It absorbs the FIFO's one-cycle read latency with a 2-entry holding buffer, never issues a read while the FIFO is empty (so the FIFO's read-error flag is never raised), and sustains one word per cycle when the downstream is always ready.

## Interface
Parameters:
- `WIDTH`, 8 — data word width; must match the FIFO's `WIDTH`.
- `CNT_WIDTH`, 16 — width of the delivered-word counter.

Ports:
- `clk_i`  in  1  — single clock; all state updates on its rising edge.
- `rst_ni`  in  1  — reset; asynchronous assert, active-low.
- `rd_en_o`  out  1  — read strobe to the FIFO (combinational).
- `rdata_i`  in  WIDTH  — FIFO read data; valid the cycle after `rd_en_o` was high.
- `empty_i`  in  1  — FIFO empty flag.
- `valid_o`  out  1  — output word available.
- `data_o`  out  WIDTH  — output word; head of the holding buffer.
- `ready_i`  in  1  — downstream accepts; a transfer occurs when `valid_o && ready_i`.
- `flush_i`  in  1  — synchronous flush of held and in-flight words.
- `count_o`  out  CNT_WIDTH  — number of words delivered, wrapping.

## Operation
- **State:**
  - `held` (0..2): words in the holding buffer, a 2-entry FIFO with head and tail.
  - `inflight` (0/1): a read was issued last cycle and its data is on `rdata_i` this cycle.
  - `count_o`.
- **Derived signals:**
  - `pop = valid_o && ready_i && !flush_i`.
  - `used = held + inflight`.
- **Read issue:** `rd_en_o = rst_ni && !flush_i && !empty_i && (used < 2 || pop)`.
  - `rd_en_o` is never high while `empty_i = 1`.
- **Capture:** at the edge ending a cycle with `inflight = 1` and no flush, `rdata_i` is written into the buffer tail.
- **Pop:** at the edge ending a cycle with `pop = 1`:
  - the head advances;
  - `count_o` increments, wrapping from all-ones to 0.
- **Simultaneous capture and pop:** `held` is unchanged; the new word enters the tail and the old head leaves. Order is preserved.
- **Output:** `valid_o = (held != 0)`; `data_o` is the head entry.
  - `data_o` stays stable while `valid_o && !ready_i`.
  - `data_o` is 0 whenever `held = 0`.
- **Invariant:** `used ≤ 2` always. The bench asserts this.
- **Flush:** a cycle with `flush_i = 1` does the following:
  - `rd_en_o = 0`;
  - no transfer is counted, even if `ready_i = 1`;
  - at the edge, `held` clears to 0 and any in-flight word is discarded, not captured;
  - `count_o` is unchanged;
  - normal issue resumes the cycle after `flush_i` falls.
- **Reset** (asynchronous, while `rst_ni = 0`):
  - `held = 0`, `inflight = 0`, `count_o = 0`;
  - buffer entries = 0, so `data_o = 0`;
  - `valid_o = 0`, `rd_en_o = 0`.
  - Reset mid-transfer drops all words.
  - The first read may issue in the first cycle after `rst_ni` rises, if `empty_i = 0`.

## Timing
- Read latency:
  - `rd_en_o` high in cycle N;
  - `rdata_i` sampled in cycle N+1;
  - `valid_o`/`data_o` present the word from cycle N+2.
- From the FIFO going non-empty with the reader idle, the first `valid_o` appears 2 cycles later.
- Throughput:
  - with `ready_i` held high and the FIFO non-empty: 1 word per cycle in steady state (`held = 1`, `inflight = 1`);
  - with `ready_i` low: at most 2 reads outstanding, after which `rd_en_o` stays low until a pop.
- `rd_en_o` is combinational from `empty_i`, `ready_i` and `flush_i`. There is no combinational path from `rdata_i` to any output.

## Test plan
- **Stream:** 5 words 0x11..0x15 preloaded, `ready_i = 1`.
  - `rd_en_o` is high for 5 consecutive cycles, then low.
  - `data_o` = 0x11..0x15 on consecutive cycles, starting 2 cycles after the first `rd_en_o`.
  - `count_o` = 5.
  - FIFO `rd_error` is never set.
- **Backpressure:** 4 words preloaded, `ready_i = 0` for 6 cycles, then 1.
  - Exactly 2 reads issue, then `rd_en_o` stays 0.
  - `data_o` holds 0x..1st word.
  - After release, all 4 words arrive in order with no gaps after the first.
- **Empty boundary:** the FIFO holds 1 word and another write arrives 3 cycles later.
  - `rd_en_o` is never high while `empty_i = 1`.
  - Both words are delivered.
  - `used` never exceeds 2.
- **Flush:** `ready_i = 0`, `held = 1` and `inflight = 1`, then `flush_i` pulses for 1 cycle.
  - `valid_o = 0` the next cycle.
  - The in-flight word is not delivered and `count_o` is unchanged.
  - Subsequent FIFO words are delivered normally.
- **Wrap:** set `CNT_WIDTH = 4` and deliver 17 words.
  - `count_o` reads 1.
  - Data order is correct across the FIFO's pointer wrap at depth 16.
- **Async reset:** assert `rst_ni = 0` mid-stream, between clock edges.
  - `valid_o`, `rd_en_o`, `data_o` and `count_o` go to 0 immediately, without waiting for a clock edge.
  - After release, operation restarts cleanly from the FIFO contents.
